mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single RAM port among NREQ cache requesters
//  (core0 icache, core0 dcache, core1 icache, core1 dcache; index = 2*core + d).

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one RAM port among NREQ cache requesters.
// It owns one transaction at a time and acks only the granted requester.

module mem_arbiter_lane (
  input  logic ren_i,
  input  logic wen_i,
  input  logic is_grant_i,
  input  logic ack_i,
  output logic active_o,
  output logic wait_o
);
  assign active_o = ren_i | wen_i;
  assign wait_o   = ~(is_grant_i & ack_i);
endmodule

module mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [DATA_W-1:0]        req_load,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     ram_err,
  output logic [31:0]              grant_cnt
);
  localparam int GW = $clog2(NREQ);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [NREQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NREQ-1:0][DATA_W-1:0] store_arr;
  logic [NREQ-1:0]             active;
  logic                        g_active, ack;
  logic                        pick_found;
  logic [GW-1:0]               pick_idx, grant_inc;
  int                          pidx;

  assign addr_arr  = req_addr;
  assign store_arr = req_store;
  assign g_active  = active[grant_q];
  assign ack       = (state_q == OWN) && g_active && (ramstate == RS_ACCESS);
  assign grant_inc = (grant_q == GW'(NREQ-1)) ? '0 : grant_q + 1'b1;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    mem_arbiter_lane u_lane (
      .ren_i      (req_ren[gi]),
      .wen_i      (req_wen[gi]),
      .is_grant_i (grant_q == GW'(gi)),
      .ack_i      (ack),
      .active_o   (active[gi]),
      .wait_o     (req_wait[gi])
    );
  end

  // Scan downward so the lowest offset from rr_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pidx       = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      pidx = int'(rr_q) + k;
      if (pidx >= NREQ) pidx = pidx - NREQ;
      if (active[GW'(pidx)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(pidx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!g_active) begin
          state_d = IDLE;
        end else begin
          ramWEN   = req_wen[grant_q];
          ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
          ramaddr  = addr_arr[grant_q];
          ramstore = store_arr[grant_q];
          if (ramstate == RS_ACCESS) begin
            state_d = IDLE;
            rr_d    = grant_inc;
            cnt_d   = cnt_q + 32'd1;
          end else if (ramstate == RS_ERROR) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_load  = ramload;
  assign ram_err   = err_q;
  assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected acks queue up as stimulus is driven
// and are matched against whichever requester sees wait low.

module tb_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [31:0] LDX = 32'hC0DE_0000;

  typedef struct {
    int          idx;
    logic [31:0] load;
  } exp_t;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic [3:0]       req_ren = '0, req_wen = '0;
  logic [3:0][31:0] addr, store;
  logic [3:0]       req_wait;
  logic [31:0]      req_load, ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN, ram_err;
  logic [1:0]       ramstate = FREE;
  logic [31:0]      grant_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // RAM returns a value derived from the address it was given.
  assign ramload = ramaddr ^ LDX;

  mem_arbiter #(.NREQ(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(addr), .req_store(store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ram_err(ram_err), .grant_cnt(grant_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i);
    exp_t e;
    e.idx  = i;
    e.load = addr[i] ^ LDX;
    sb.push_back(e);
  endtask

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    int   lows, idx;
    exp_t e;
    @(negedge CLK);
    lows = 0;
    idx  = 0;
    for (int i = 0; i < 4; i++)
      if (req_wait[i] === 1'b0) begin
        lows++;
        idx = i;
      end
    if (lows != 0) begin
      chk("one_wait_low", 64'(lows), 64'd1);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.idx  = -1;
        e.load = '0;
      end
      chk("ack_idx", 64'(idx), 64'(e.idx));
      chk("ack_load", 64'(req_load), 64'(e.load));
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    addr  = {32'h300, 32'h200, 32'h40, 32'h1000};
    store = {32'h33, 32'hDEADBEEF, 32'h11, 32'h00};

    // Reset state
    #2;
    chk("rst_wait", 64'(req_wait), 64'hF);
    chk("rst_ren", 64'(ramREN), 64'd0);
    chk("rst_wen", 64'(ramWEN), 64'd0);
    chk("rst_addr", 64'(ramaddr), 64'd0);
    chk("rst_store", 64'(ramstore), 64'd0);
    chk("rst_err", 64'(ram_err), 64'd0);
    chk("rst_cnt", 64'(grant_cnt), 64'd0);
    tick();
    nRST = 1'b1;

    // Single read by requester 1, ACCESS in first OWN cycle
    req_ren[1] = 1'b1;
    ramstate   = BUSY;
    tick();
    chk("t1_ren", 64'(ramREN), 64'd1);
    chk("t1_addr", 64'(ramaddr), 64'h40);
    chk("t1_wait_busy", 64'(req_wait), 64'hF);
    ramstate = ACCESS;
    push(1);
    tick();
    req_ren  = '0;
    ramstate = FREE;
    chk("t1_cnt", 64'(grant_cnt), 64'd1);
    chk("t1_wait_idle", 64'(req_wait), 64'hF);

    // All four hold reads; rotation continues from 2
    req_ren  = 4'hF;
    ramstate = ACCESS;
    for (int k = 0; k < 8; k++) push((2 + k) % 4);
    for (int k = 0; k < 16; k++) tick();
    req_ren  = '0;
    ramstate = FREE;
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    chk("t2_cnt", 64'(grant_cnt), 64'd9);

    // Requester 2 asserts both enables -> write
    req_ren[2] = 1'b1;
    req_wen[2] = 1'b1;
    ramstate   = BUSY;
    tick();
    chk("t3_wen", 64'(ramWEN), 64'd1);
    chk("t3_ren", 64'(ramREN), 64'd0);
    chk("t3_store", 64'(ramstore), 64'hDEADBEEF);
    chk("t3_addr", 64'(ramaddr), 64'h200);
    ramstate = ACCESS;
    push(2);
    tick();
    req_ren  = '0;
    req_wen  = '0;
    ramstate = FREE;
    chk("t3_cnt", 64'(grant_cnt), 64'd10);

    // Requester 3 abandons its grant; ACCESS after the drop must not ack
    req_ren[3] = 1'b1;
    ramstate   = BUSY;
    tick();
    chk("t4_addr", 64'(ramaddr), 64'h300);
    req_ren[3] = 1'b0;
    ramstate   = ACCESS;
    chk("t4_abort_wait", 64'(req_wait), 64'hF);
    tick();
    ramstate = FREE;
    chk("t4_cnt", 64'(grant_cnt), 64'd10);
    req_ren  = 4'b1001;
    tick();
    chk("t4_regrant3", 64'(ramaddr), 64'h300);
    ramstate = ACCESS;
    push(3);
    tick();
    req_ren[3] = 1'b0;
    ramstate   = FREE;
    chk("t4_cnt2", 64'(grant_cnt), 64'd11);

    // Requester 0 owns the RAM while it reports ERROR for three cycles
    tick();
    chk("t5_addr", 64'(ramaddr), 64'h1000);
    ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_err", 64'(ram_err), 64'd1);
      chk("t5_wait_held", 64'(req_wait), 64'hF);
    end
    ramstate = ACCESS;
    push(0);
    tick();
    req_ren  = '0;
    ramstate = FREE;
    chk("t5_err_sticky", 64'(ram_err), 64'd1);
    chk("t5_cnt", 64'(grant_cnt), 64'd12);

    // Asynchronous reset in the middle of an owned transaction
    req_ren[2] = 1'b1;
    ramstate   = BUSY;
    tick();
    chk("t6_pre_ren", 64'(ramREN), 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_ren", 64'(ramREN), 64'd0);
    chk("t6_wen", 64'(ramWEN), 64'd0);
    chk("t6_wait", 64'(req_wait), 64'hF);
    chk("t6_cnt", 64'(grant_cnt), 64'd0);
    chk("t6_err", 64'(ram_err), 64'd0);
    req_ren = 4'b1001;
    tick();
    nRST = 1'b1;
    tick();
    chk("t6_grant0_addr", 64'(ramaddr), 64'h1000);
    chk("t6_grant0_ren", 64'(ramREN), 64'd1);
    ramstate = ACCESS;
    push(0);
    tick();
    req_ren[0] = 1'b0;
    ramstate   = FREE;
    chk("t6_cnt1", 64'(grant_cnt), 64'd1);
    req_ren = '0;
    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
